stage_controller: RTL and testbench

Multi-cycle sequencer for the RockWave core. It steps each instruction through fetch, decode, execute, memory and writeback, and drives one enable per stage; `decode_en` feeds the instruction decode stage directly. It also handles the instruction-memory and data-memory ready handshakes, stall, a data-memory watchdog, and a retired-instruction counter.

---
 rtl/stage_controller.sv | 118 +++++++++++
 tb/tb_stage_controller.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/stage_controller.sv
// Multi-cycle instruction sequencer: steps each instruction through fetch, decode, execute,
// memory and writeback, with stall, memory-ready handshakes, a data-memory watchdog and instret.
module stage_controller #(
   parameter int XLEN        = 32,
   parameter int MEM_TIMEOUT = 16
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            run_i,
   input  logic            stall_i,
   input  logic            imem_ready_i,
   input  logic            mem_access_i,
   input  logic            dmem_ready_i,
   output logic            fetch_en_o,
   output logic            decode_en_o,
   output logic            execute_en_o,
   output logic            memory_en_o,
   output logic            writeback_en_o,
   output logic [2:0]      state_o,
   output logic [XLEN-1:0] instret_o,
   output logic            mem_timeout_err_o
);

   localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_FETCH     = 3'd1,
      ST_DECODE    = 3'd2,
      ST_EXECUTE   = 3'd3,
      ST_MEMORY    = 3'd4,
      ST_WRITEBACK = 3'd5,
      ST_ERROR     = 3'd6,
      ST_UNUSED    = 3'd7
   } state_e;

   state_e            state_q;
   logic [WAIT_W-1:0] wait_q;
   logic [XLEN-1:0]   instret_q;
   logic [XLEN-1:0]   instret_d;
   logic              err_q;

   assign instret_d = instret_q + XLEN'(1);

   // Sequencer, watchdog, retire counter and sticky timeout flag; stall freezes everything.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q   <= ST_IDLE;
         wait_q    <= '0;
         instret_q <= '0;
         err_q     <= 1'b0;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (!stall_i && run_i) begin
                  state_q <= ST_FETCH;
               end
            end
            ST_FETCH: begin
               if (!stall_i && imem_ready_i) begin
                  state_q <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               if (!stall_i) begin
                  state_q <= ST_EXECUTE;
               end
            end
            ST_EXECUTE: begin
               if (!stall_i) begin
                  if (mem_access_i) begin
                     state_q <= ST_MEMORY;
                     wait_q  <= '0;
                  end else begin
                     state_q <= ST_WRITEBACK;
                  end
               end
            end
            ST_MEMORY: begin
               // A ready arriving on the last permitted cycle still completes the access.
               if (!stall_i) begin
                  if (dmem_ready_i) begin
                     state_q <= ST_WRITEBACK;
                  end else if (wait_q == WAIT_LAST) begin
                     state_q <= ST_ERROR;
                     err_q   <= 1'b1;
                  end else begin
                     wait_q  <= wait_q + WAIT_W'(1);
                  end
               end
            end
            ST_WRITEBACK: begin
               if (!stall_i) begin
                  instret_q <= instret_d;
                  state_q   <= run_i ? ST_FETCH : ST_IDLE;
               end
            end
            ST_ERROR: begin
               state_q <= ST_ERROR;
            end
            default: begin
               state_q <= ST_IDLE;
            end
         endcase
      end
   end

   assign fetch_en_o        = (state_q == ST_FETCH)     & ~stall_i;
   assign decode_en_o       = (state_q == ST_DECODE)    & ~stall_i;
   assign execute_en_o      = (state_q == ST_EXECUTE)   & ~stall_i;
   assign memory_en_o       = (state_q == ST_MEMORY)    & ~stall_i;
   assign writeback_en_o    = (state_q == ST_WRITEBACK) & ~stall_i;
   assign state_o           = state_q;
   assign instret_o         = instret_q;
   assign mem_timeout_err_o = err_q;

endmodule

// File: tb/tb_stage_controller.sv
// Directed bench for stage_controller: hand-computed state, enable, instret and error expectations.
module tb_stage_controller;

   localparam int XLEN = 4;
   localparam int MT   = 16;

   logic            clk = 1'b0;
   logic            rst = 1'b0;
   logic            run = 1'b0;
   logic            stall = 1'b0;
   logic            imem_ready = 1'b0;
   logic            mem_access = 1'b0;
   logic            dmem_ready = 1'b0;
   logic            fetch_en, decode_en, execute_en, memory_en, writeback_en;
   logic [2:0]      state;
   logic [XLEN-1:0] instret;
   logic            mem_timeout_err;

   int checks = 0;
   int errors = 0;
   int exp_ret = 0;

   stage_controller #(.XLEN(XLEN), .MEM_TIMEOUT(MT)) dut (
      .clk_i             (clk),
      .rst_i             (rst),
      .run_i             (run),
      .stall_i           (stall),
      .imem_ready_i      (imem_ready),
      .mem_access_i      (mem_access),
      .dmem_ready_i      (dmem_ready),
      .fetch_en_o        (fetch_en),
      .decode_en_o       (decode_en),
      .execute_en_o      (execute_en),
      .memory_en_o       (memory_en),
      .writeback_en_o    (writeback_en),
      .state_o           (state),
      .instret_o         (instret),
      .mem_timeout_err_o (mem_timeout_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Checks state plus the one-hot enable pattern that state implies under the current stall.
   task automatic chk_st(input string tag, input logic [2:0] exp_state);
      logic [4:0] exp_en;
      exp_en = 5'b00000;
      if (!stall) begin
         case (exp_state)
            3'd1:    exp_en = 5'b00001;
            3'd2:    exp_en = 5'b00010;
            3'd3:    exp_en = 5'b00100;
            3'd4:    exp_en = 5'b01000;
            3'd5:    exp_en = 5'b10000;
            default: exp_en = 5'b00000;
         endcase
      end
      chk({tag, ".state"}, {29'd0, state}, {29'd0, exp_state});
      chk({tag, ".en"}, {27'd0, writeback_en, memory_en, execute_en, decode_en, fetch_en},
          {27'd0, exp_en});
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Asynchronous reset, no clock edge needed
      #1 rst = 1'b1;
      #1;
      chk_st("reset", 3'd0);
      chk("reset.instret", {28'd0, instret}, 32'd0);
      chk("reset.err", {31'd0, mem_timeout_err}, 32'd0);
      tick();
      tick();
      rst = 1'b0;
      tick();
      chk_st("idle_hold", 3'd0);

      // Three back-to-back non-memory instructions
      run = 1'b1;
      imem_ready = 1'b1;
      mem_access = 1'b0;
      dmem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         tick(); chk_st("nm.F", 3'd1);
         tick(); chk_st("nm.D", 3'd2);
         tick(); chk_st("nm.E", 3'd3);
         tick(); chk_st("nm.W", 3'd5);
         chk("nm.instret_in_wb", {28'd0, instret}, exp_ret);
         exp_ret++;
      end
      tick();
      chk_st("nm.F4", 3'd1);
      chk("nm.instret3", {28'd0, instret}, 32'd3);

      // Load with dmem_ready low for three MEMORY cycles
      mem_access = 1'b1;
      tick(); chk_st("ld.D", 3'd2);
      tick(); chk_st("ld.E", 3'd3);
      for (int i = 0; i < 3; i++) begin
         tick(); chk_st("ld.M_wait", 3'd4);
      end
      tick();
      dmem_ready = 1'b1;
      chk_st("ld.M4", 3'd4);
      tick(); chk_st("ld.W", 3'd5);
      tick(); chk_st("ld.F", 3'd1);
      exp_ret++;
      chk("ld.instret", {28'd0, instret}, exp_ret);
      chk("ld.err", {31'd0, mem_timeout_err}, 32'd0);

      // Ready on the 16th MEMORY cycle wins over the watchdog
      dmem_ready = 1'b0;
      tick(); chk_st("bd.D", 3'd2);
      tick(); chk_st("bd.E", 3'd3);
      tick(); chk_st("bd.M1", 3'd4);
      for (int i = 0; i < MT - 1; i++) tick();
      chk_st("bd.M16", 3'd4);
      dmem_ready = 1'b1;
      tick(); chk_st("bd.W", 3'd5);
      chk("bd.err", {31'd0, mem_timeout_err}, 32'd0);
      tick(); chk_st("bd.F", 3'd1);
      exp_ret++;
      chk("bd.instret", {28'd0, instret}, exp_ret);

      // Sixteen MEMORY cycles without ready: timeout into ERROR
      dmem_ready = 1'b0;
      tick(); chk_st("to.D", 3'd2);
      tick(); chk_st("to.E", 3'd3);
      tick(); chk_st("to.M1", 3'd4);
      for (int i = 0; i < MT - 1; i++) tick();
      chk_st("to.M16", 3'd4);
      chk("to.err_before", {31'd0, mem_timeout_err}, 32'd0);
      tick(); chk_st("to.ERR", 3'd6);
      chk("to.err", {31'd0, mem_timeout_err}, 32'd1);
      run = 1'b0;
      tick();
      run = 1'b1;
      dmem_ready = 1'b1;
      tick(); chk_st("to.ERR_hold", 3'd6);
      chk("to.err_hold", {31'd0, mem_timeout_err}, 32'd1);
      chk("to.instret_hold", {28'd0, instret}, exp_ret);
      #2 rst = 1'b1;
      #1;
      chk_st("to.rst", 3'd0);
      chk("to.rst_err", {31'd0, mem_timeout_err}, 32'd0);
      chk("to.rst_instret", {28'd0, instret}, 32'd0);
      exp_ret = 0;
      tick();
      rst = 1'b0;

      // Stall ignores imem_ready in FETCH, freezes DECODE and WRITEBACK
      mem_access = 1'b0;
      tick(); chk_st("st.F", 3'd1);
      stall = 1'b1;
      #1 chk_st("st.F_stalled", 3'd1);
      tick(); chk_st("st.F_hold", 3'd1);
      stall = 1'b0;
      tick(); chk_st("st.D", 3'd2);
      stall = 1'b1;
      #1 chk_st("st.D_stalled", 3'd2);
      for (int i = 0; i < 4; i++) begin
         tick(); chk_st("st.D_hold", 3'd2);
      end
      stall = 1'b0;
      #1 chk("st.D_release", {31'd0, decode_en}, 32'd1);
      tick(); chk_st("st.E", 3'd3);

      // Run dropped in EXECUTE: instruction still retires, then IDLE
      run = 1'b0;
      tick(); chk_st("rd.W", 3'd5);
      stall = 1'b1;
      tick(); chk_st("rd.W_stalled", 3'd5);
      chk("rd.instret_stalled", {28'd0, instret}, 32'd0);
      stall = 1'b0;
      tick(); chk_st("rd.IDLE", 3'd0);
      chk("rd.instret", {28'd0, instret}, 32'd1);
      tick(); chk_st("rd.IDLE_hold", 3'd0);

      // Retire until the 4-bit counter wraps
      run = 1'b1;
      tick();
      for (int i = 0; i < 14 * 4; i++) tick();
      chk_st("wr.F", 3'd1);
      chk("wr.instret_max", {28'd0, instret}, 32'd15);
      for (int i = 0; i < 4; i++) tick();
      chk("wr.instret_wrap", {28'd0, instret}, 32'd0);
      for (int i = 0; i < 4; i++) tick();
      chk("wr.instret_after", {28'd0, instret}, 32'd1);

      // Reset pulse while waiting in MEMORY
      mem_access = 1'b1;
      dmem_ready = 1'b0;
      tick(); tick(); tick();
      chk_st("mr.M", 3'd4);
      #2 rst = 1'b1;
      #1;
      chk_st("mr.rst", 3'd0);
      chk("mr.instret", {28'd0, instret}, 32'd0);
      chk("mr.err", {31'd0, mem_timeout_err}, 32'd0);
      tick();
      rst = 1'b0;
      run = 1'b0;
      tick(); chk_st("mr.idle", 3'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
